// File: rtl/demux8_collector.sv
// Registered 1-to-8 demultiplexer and frame collector.
// Steers handshaked words into eight slots and holds the full frame until it is acknowledged.
module demux8_collector #(
    parameter int Size = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mode,
    input  logic [2:0]      select,
    input  logic [Size-1:0] data_i,
    input  logic            data_i_valid,
    output logic            data_i_ready,
    output logic [Size-1:0] data_o00,
    output logic [Size-1:0] data_o01,
    output logic [Size-1:0] data_o02,
    output logic [Size-1:0] data_o03,
    output logic [Size-1:0] data_o04,
    output logic [Size-1:0] data_o05,
    output logic [Size-1:0] data_o06,
    output logic [Size-1:0] data_o07,
    output logic [7:0]      data_o_valid,
    output logic            frame_done,
    input  logic            frame_ack
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [Size-1:0] slot_q [8];
    logic [Size-1:0] slot_d [8];
    logic [7:0]      vld_q, vld_d;
    logic            done_q, done_d;
    logic [2:0]      idx;
    logic            xfer;

    assign data_i_ready = !reset && (state_q == FILL);
    assign xfer         = data_i_valid && data_i_ready;
    assign idx          = mode ? cnt_q : select;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        vld_d   = vld_q;
        done_d  = done_q;
        if (xfer) begin
            slot_d[idx] = data_i;
            vld_d       = vld_q | (8'b1 << idx);
            if (mode) begin
                cnt_d = cnt_q + 3'd1;
            end
            // Completion on the edge that fills the last empty slot
            if (vld_d == 8'hFF) begin
                state_d = HOLD;
                done_d  = 1'b1;
            end
        end else if (state_q == HOLD && frame_ack) begin
            state_d = FILL;
            cnt_d   = 3'd0;
            vld_d   = 8'h00;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= 3'd0;
            slot_q  <= '{default: '0};
            vld_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign data_o00     = slot_q[0];
    assign data_o01     = slot_q[1];
    assign data_o02     = slot_q[2];
    assign data_o03     = slot_q[3];
    assign data_o04     = slot_q[4];
    assign data_o05     = slot_q[5];
    assign data_o06     = slot_q[6];
    assign data_o07     = slot_q[7];
    assign data_o_valid = vld_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_demux8_collector.sv
// Scoreboard bench for demux8_collector: a slot-array reference model
// pushes the expected outputs per edge, a monitor compares them on the falling edge.
module tb_demux8_collector;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic [2:0] select;
    logic [7:0] data_i;
    logic       data_i_valid;
    logic       data_i_ready;
    logic [7:0] data_o00, data_o01, data_o02, data_o03;
    logic [7:0] data_o04, data_o05, data_o06, data_o07;
    logic [7:0] data_o_valid;
    logic       frame_done;
    logic       frame_ack;

    demux8_collector #(.Size(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .select       (select),
        .data_i       (data_i),
        .data_i_valid (data_i_valid),
        .data_i_ready (data_i_ready),
        .data_o00     (data_o00),
        .data_o01     (data_o01),
        .data_o02     (data_o02),
        .data_o03     (data_o03),
        .data_o04     (data_o04),
        .data_o05     (data_o05),
        .data_o06     (data_o06),
        .data_o07     (data_o07),
        .data_o_valid (data_o_valid),
        .frame_done   (frame_done),
        .frame_ack    (frame_ack)
    );

    always #5 clock = ~clock;

    logic [7:0] dout [8];
    assign dout[0] = data_o00;
    assign dout[1] = data_o01;
    assign dout[2] = data_o02;
    assign dout[3] = data_o03;
    assign dout[4] = data_o04;
    assign dout[5] = data_o05;
    assign dout[6] = data_o06;
    assign dout[7] = data_o07;

    typedef struct packed {
        logic [7:0][7:0] d;
        logic [7:0]      v;
        logic            done;
        logic            hold;
    } exp_t;

    exp_t sbq [$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: plain slot array, per-slot flags, wrap-around pointer
    logic [7:0] m_data [8];
    bit         m_full [8];
    int         m_ptr;
    bit         m_hold;

    function automatic int filled();
        int n = 0;
        for (int k = 0; k < 8; k++) n += m_full[k] ? 1 : 0;
        return n;
    endfunction

    task automatic model_edge(input bit r, input bit v, input bit m,
                              input bit [2:0] s, input bit [7:0] d,
                              input bit a);
        int slot;
        if (r) begin
            for (int k = 0; k < 8; k++) begin
                m_data[k] = 8'h00;
                m_full[k] = 1'b0;
            end
            m_ptr  = 0;
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (v) begin
                slot = m ? m_ptr : int'(s);
                m_data[slot] = d;
                m_full[slot] = 1'b1;
                if (m) m_ptr = (m_ptr + 1) % 8;
                if (filled() == 8) m_hold = 1'b1;
            end
        end else if (a) begin
            for (int k = 0; k < 8; k++) m_full[k] = 1'b0;
            m_ptr  = 0;
            m_hold = 1'b0;
        end
    endtask

    task automatic cyc(input bit r, input bit v, input bit m,
                       input bit [2:0] s, input bit [7:0] d, input bit a);
        exp_t e;
        reset        = r;
        data_i_valid = v;
        mode         = m;
        select       = s;
        data_i       = d;
        frame_ack    = a;
        @(posedge clock);
        model_edge(r, v, m, s, d, a);
        for (int k = 0; k < 8; k++) begin
            e.d[k] = m_data[k];
            e.v[k] = m_full[k];
        end
        e.done = m_hold;
        e.hold = m_hold;
        sbq.push_back(e);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        bit   bad;
        logic rdy;
        if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            bad = 1'b0;
            vectors++;
            for (int k = 0; k < 8; k++) begin
                if (dout[k] !== e.d[k]) begin
                    $display("FAIL slot%0d: got %h want %h at %0t",
                             k, dout[k], e.d[k], $time);
                    bad = 1'b1;
                end
            end
            if (data_o_valid !== e.v) begin
                $display("FAIL valid: got %h want %h at %0t",
                         data_o_valid, e.v, $time);
                bad = 1'b1;
            end
            if (frame_done !== e.done) begin
                $display("FAIL frame_done: got %b want %b at %0t",
                         frame_done, e.done, $time);
                bad = 1'b1;
            end
            rdy = !e.hold && !reset;
            if (data_i_ready !== rdy) begin
                $display("FAIL ready: got %b want %b at %0t",
                         data_i_ready, rdy, $time);
                bad = 1'b1;
            end
            if (bad) miscompares++;
        end
    end

    initial begin
        // Reset, then sequential fill 10..17 and extra words while held
        cyc(1, 0, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 1, 0, 8'h10 + 8'(k), 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 8'hEE, 0);
        // Ack, then next sequential word lands in slot 0
        cyc(0, 0, 1, 0, 8'h00, 1);
        cyc(0, 0, 1, 0, 8'h00, 0);
        cyc(0, 1, 1, 0, 8'h99, 0);
        cyc(0, 0, 1, 0, 8'h00, 1);

        // Addressed fill with overwrite of slot 3
        cyc(1, 0, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 3, 8'hAA, 0);
        cyc(0, 1, 0, 3, 8'hBB, 0);
        for (int k = 0; k < 8; k++)
            if (k != 3) cyc(0, 1, 0, 3'(k), 8'(k), 0);
        cyc(0, 1, 0, 1, 8'h77, 0);
        cyc(0, 0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 0, 8'h00, 0);

        // Mixed mode: counter unaffected by addressed write
        cyc(1, 0, 0, 0, 8'h00, 0);
        cyc(0, 1, 1, 0, 8'h11, 0);
        cyc(0, 1, 1, 0, 8'h22, 0);
        cyc(0, 1, 0, 5, 8'h55, 0);
        cyc(0, 1, 1, 0, 8'h33, 0);
        cyc(0, 0, 1, 0, 8'h00, 1);

        // Bubbles: valid toggles, ack in FILL ignored
        cyc(1, 0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 18; k++)
            cyc(0, k % 2 == 0, 1, 3'($urandom_range(0, 7)),
                8'($urandom), k % 5 == 1);
        cyc(0, 0, 0, 0, 8'h00, 1);

        // Reset mid-frame
        cyc(1, 0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, 8'hC0 + 8'(k), 0);
        cyc(1, 1, 1, 0, 8'hDD, 0);
        cyc(0, 1, 1, 0, 8'h5A, 0);
        cyc(0, 0, 1, 0, 8'h00, 0);

        // Random traffic
        for (int k = 0; k < 600; k++)
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1,
                3'($urandom_range(0, 7)),
                8'($urandom),
                $urandom_range(0, 3) == 0);

        cyc(0, 0, 0, 0, 8'h00, 0);
        @(negedge clock);
        #1;
        if (sbq.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", sbq.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
